// File: rtl/mcpu_pkg.sv
// Shared definitions for the 16-bit core pipeline.
// Memory commands, write-enable codes and the EX/MEM payload layout.
package mcpu_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_REG_AW  = 4;
    localparam int DEF_MEMRW_W = 2;

    localparam logic [1:0] MEMRW_IDLE  = 2'b00;
    localparam logic [1:0] MEMRW_READ  = 2'b01;
    localparam logic [1:0] MEMRW_WRITE = 2'b10;

    localparam logic WRITE_EN  = 1'b1;
    localparam logic WRITE_DIS = 1'b0;

    typedef struct packed {
        logic [DEF_MEMRW_W-1:0] memrw;
        logic [DEF_DATA_W-1:0]  memaddr;
        logic [DEF_DATA_W-1:0]  memdata;
        logic [DEF_DATA_W-1:0]  wdata;
        logic [DEF_REG_AW-1:0]  waddr;
        logic                   we;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: payload register plus valid bit.
// Clear wins over load; payload is only written on load.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM boundary register with a 2-entry skid buffer.
// ex_ready is derived from the skid valid bit only, never from mem_ready.
module ex_mem_skid
    import mcpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int MEMRW_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [MEMRW_W-1:0] ex_memrw,
    input  logic [DATA_W-1:0]  ex_memaddr,
    input  logic [DATA_W-1:0]  ex_memdata,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic [REG_AW-1:0]  ex_waddr,
    input  logic               ex_we,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [MEMRW_W-1:0] mem_memrw,
    output logic [DATA_W-1:0]  mem_memaddr,
    output logic [DATA_W-1:0]  mem_memdata,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [REG_AW-1:0]  mem_waddr,
    output logic               mem_we,
    output logic               skid_full
);

    localparam int PAY_W = MEMRW_W + 3*DATA_W + REG_AW + 1;

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] main_d;
    logic [PAY_W-1:0] main_q;
    logic [PAY_W-1:0] skid_q;
    logic             main_valid;
    logic             skid_valid;
    logic             main_load;
    logic             main_clr;
    logic             main_sel_skid;
    logic             skid_load;
    logic             skid_clr;
    logic             accept;
    logic             consume;

    logic [MEMRW_W-1:0] m_memrw;
    logic               m_we;

    assign in_pay = {ex_memrw, ex_memaddr, ex_memdata,
                     ex_wdata, ex_waddr, ex_we};

    assign ex_ready = ~skid_valid & ~rst;
    assign accept   = ex_valid & ex_ready;
    assign consume  = main_valid & mem_ready;

    always_comb begin
        main_load     = 1'b0;
        main_clr      = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (skid_valid) begin
            if (consume) begin
                main_load     = 1'b1;
                main_sel_skid = 1'b1;
                skid_clr      = 1'b1;
            end
        end else if (accept) begin
            if (!main_valid || consume)
                main_load = 1'b1;
            else
                skid_load = 1'b1;
        end else if (consume) begin
            main_clr = 1'b1;
        end
    end

    assign main_d = main_sel_skid ? skid_q : in_pay;

    pipe_slot #(.W(PAY_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_d),
        .q     (main_q),
        .valid (main_valid)
    );

    pipe_slot #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_pay),
        .q     (skid_q),
        .valid (skid_valid)
    );

    assign {m_memrw, mem_memaddr, mem_memdata,
            mem_wdata, mem_waddr, m_we} = main_q;

    // Bubbles must never issue a memory op or a register write.
    assign mem_valid = main_valid;
    assign mem_we    = main_valid & m_we;
    assign mem_memrw = main_valid ? m_memrw : MEMRW_W'(MEMRW_IDLE);
    assign skid_full = skid_valid;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed table-driven bench for ex_mem_skid.
// Each vector drives one cycle and checks the outputs just after the edge.
module tb_ex_mem_skid;
    import mcpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  ex_memrw;
    logic [15:0] ex_memaddr;
    logic [15:0] ex_memdata;
    logic [15:0] ex_wdata;
    logic [3:0]  ex_waddr;
    logic        ex_we;
    logic        mem_valid;
    logic        mem_ready;
    logic [1:0]  mem_memrw;
    logic [15:0] mem_memaddr;
    logic [15:0] mem_memdata;
    logic [15:0] mem_wdata;
    logic [3:0]  mem_waddr;
    logic        mem_we;
    logic        skid_full;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_mem_skid #(.DATA_W(16), .REG_AW(4), .MEMRW_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_memrw    (ex_memrw),
        .ex_memaddr  (ex_memaddr),
        .ex_memdata  (ex_memdata),
        .ex_wdata    (ex_wdata),
        .ex_waddr    (ex_waddr),
        .ex_we       (ex_we),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_memrw   (mem_memrw),
        .mem_memaddr (mem_memaddr),
        .mem_memdata (mem_memdata),
        .mem_wdata   (mem_wdata),
        .mem_waddr   (mem_waddr),
        .mem_we      (mem_we),
        .skid_full   (skid_full)
    );

    typedef struct {
        logic            fl;
        logic            ev;
        ex_mem_payload_t in;
        logic            mr;
        logic            emv;
        ex_mem_payload_t ex;
        logic            esf;
        logic            eer;
    } vec_t;

    vec_t vecs[$];

    function automatic ex_mem_payload_t pl(
        logic [1:0] rw, logic [15:0] a, logic [15:0] d,
        logic [15:0] wd, logic [3:0] wa, logic we);
        ex_mem_payload_t p;
        p.memrw   = rw;
        p.memaddr = a;
        p.memdata = d;
        p.wdata   = wd;
        p.waddr   = wa;
        p.we      = we;
        return p;
    endfunction

    function automatic void add(
        logic fl, logic ev, ex_mem_payload_t in, logic mr,
        logic emv, ex_mem_payload_t ex, logic esf, logic eer);
        vec_t v;
        v.fl  = fl;
        v.ev  = ev;
        v.in  = in;
        v.mr  = mr;
        v.emv = emv;
        v.ex  = ex;
        v.esf = esf;
        v.eer = eer;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic emv, ex_mem_payload_t ex,
                           logic esf, logic eer);
        chk({tag, ".mem_valid"}, 16'(mem_valid), 16'(emv));
        chk({tag, ".mem_memrw"}, 16'(mem_memrw), 16'(ex.memrw));
        chk({tag, ".mem_memaddr"}, mem_memaddr, ex.memaddr);
        chk({tag, ".mem_memdata"}, mem_memdata, ex.memdata);
        chk({tag, ".mem_wdata"}, mem_wdata, ex.wdata);
        chk({tag, ".mem_waddr"}, 16'(mem_waddr), 16'(ex.waddr));
        chk({tag, ".mem_we"}, 16'(mem_we), 16'(ex.we));
        chk({tag, ".skid_full"}, 16'(skid_full), 16'(esf));
        chk({tag, ".ex_ready"}, 16'(ex_ready), 16'(eer));
    endtask

    task automatic drive(logic fl, logic ev, ex_mem_payload_t in,
                         logic mr);
        flush      = fl;
        ex_valid   = ev;
        ex_memrw   = in.memrw;
        ex_memaddr = in.memaddr;
        ex_memdata = in.memdata;
        ex_wdata   = in.wdata;
        ex_waddr   = in.waddr;
        ex_we      = in.we;
        mem_ready  = mr;
    endtask

    ex_mem_payload_t z;
    ex_mem_payload_t s;

    initial begin
        z = pl(MEMRW_IDLE, 0, 0, 0, 0, 0);
        // pass-through and streaming
        add(0, 1, pl(0, 0, 0, 1, 1, 1), 1, 1, pl(0, 0, 0, 1, 1, 1), 0, 1);
        add(0, 1, pl(0, 0, 0, 2, 2, 1), 1, 1, pl(0, 0, 0, 2, 2, 1), 0, 1);
        add(0, 1, pl(0, 0, 0, 3, 3, 1), 1, 1, pl(0, 0, 0, 3, 3, 1), 0, 1);
        add(0, 1, pl(0, 0, 0, 4, 4, 1), 1, 1, pl(0, 0, 0, 4, 4, 1), 0, 1);
        add(0, 0, z, 1, 0, pl(0, 0, 0, 4, 4, 0), 0, 1);
        // skid event and drain in order
        add(0, 1, pl(1, 3, 0, 5, 5, 1), 1, 1, pl(1, 3, 0, 5, 5, 1), 0, 1);
        add(0, 1, pl(2, 4, 6, 6, 6, 1), 0, 1, pl(1, 3, 0, 5, 5, 1), 1, 0);
        add(0, 1, pl(0, 0, 0, 7, 7, 1), 0, 1, pl(1, 3, 0, 5, 5, 1), 1, 0);
        add(0, 0, z, 1, 1, pl(2, 4, 6, 6, 6, 1), 0, 1);
        add(0, 0, z, 1, 0, pl(0, 4, 6, 6, 6, 0), 0, 1);
        // flush with both slots full and a live input
        add(0, 1, pl(2, 2, 2, 8, 8, 1), 0, 1, pl(2, 2, 2, 8, 8, 1), 0, 1);
        add(0, 1, pl(1, 5, 5, 9, 9, 1), 0, 1, pl(2, 2, 2, 8, 8, 1), 1, 0);
        add(1, 1, pl(2, 7, 7, 10, 10, 1), 0, 0, pl(0, 2, 2, 8, 8, 0), 0, 1);
        add(0, 0, z, 1, 0, pl(0, 2, 2, 8, 8, 0), 0, 1);
        // backpressure stability
        add(0, 1, pl(1, 2, 0, 11, 11, 0), 0, 1, pl(1, 2, 0, 11, 11, 0), 0, 1);
        for (int i = 0; i < 5; i++)
            add(0, 0, z, 0, 1, pl(1, 2, 0, 11, 11, 0), 0, 1);
        add(0, 0, z, 1, 0, pl(0, 2, 0, 11, 11, 0), 0, 1);

        rst = 1'b1;
        drive(0, 0, z, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, z, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fl, vecs[i].ev, vecs[i].in, vecs[i].mr);
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].emv, vecs[i].ex,
                    vecs[i].esf, vecs[i].eer);
            @(negedge clk);
        end

        // async reset with both slots full
        drive(0, 1, pl(2, 1, 1, 12, 12, 1), 0);
        @(posedge clk);
        #1;
        drive(0, 1, pl(2, 1, 1, 13, 13, 1), 0);
        @(posedge clk);
        #1;
        chk("pre_rst.skid_full", 16'(skid_full), 16'd1);
        chk("pre_rst.mem_wdata", mem_wdata, 16'd12);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, z, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, z, 1);
        #1;
        chk("post_rst.ex_ready", 16'(ex_ready), 16'd1);
        @(posedge clk);
        #1;
        chk("post_rst.mem_valid", 16'(mem_valid), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
Parametrised EX→MEM pipeline boundary register, the successor to the plain stall-only EX/MEM latch.
- Carries the memory-op and writeback payload with valid/ready handshakes on both sides.
- A 2-entry skid buffer sustains one transfer per cycle while cutting the combinational ready path.
- Synchronous flush inserts a bubble.
- Sits between the execute stage and the memory-access stage of the 16-bit core.

Parameters:
DATA_W, 16, width of memaddr, memdata and wdata
REG_AW, 4, width of register-file write address
MEMRW_W, 2, width of memory read/write command

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous flush; discards all held and incoming entries
ex_valid  in  1  EX presents a valid entry
ex_ready  out  1  stage can accept an entry this cycle
ex_memrw  in  MEMRW_W  memory command (idle/read/write)
ex_memaddr  in  DATA_W  memory address
ex_memdata  in  DATA_W  store data
ex_wdata  in  DATA_W  writeback data
ex_waddr  in  REG_AW  writeback register address
ex_we  in  1  writeback enable
mem_valid  out  1  entry presented to MEM is valid
mem_ready  in  1  MEM consumes the entry this cycle
mem_memrw  out  MEMRW_W  command; forced to MEMRW_IDLE when mem_valid=0
mem_memaddr  out  DATA_W  address
mem_memdata  out  DATA_W  store data
mem_wdata  out  DATA_W  writeback data
mem_waddr  out  REG_AW  writeback address
mem_we  out  1  writeback enable; forced 0 when mem_valid=0
skid_full  out  1  skid slot occupied (debug/perf)

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous and active-high.
  - While rst=1: main and skid slots are empty and every payload register is 0.
  - Outputs during reset: mem_valid=0, mem_memrw=MEMRW_IDLE, mem_we=0, all data outputs 0, skid_full=0, ex_ready=0.
- Storage: main slot (drives mem_* outputs) and skid slot, each payload plus a valid bit.
- ex_ready = ~skid_valid & ~rst. It is registered-derived and never depends combinationally on mem_ready.
- Handshakes:
  - Accept = ex_valid & ex_ready.
  - Consume = mem_valid & mem_ready.
  - Payload inputs are sampled only on accept. Outputs are stable while mem_valid=1 and mem_ready=0.
- Latency: an accepted entry appears at mem_* on the next cycle when main is empty or being consumed. Throughput is 1 entry/cycle.
- Per-cycle update, evaluated in priority order:
  1. flush=1: main_valid←0 and skid_valid←0. An accept in the same cycle is dropped. Payload registers may hold stale values, which the valid-masking hides.
  2. Skid full and consume: skid→main; skid_valid←0. No accept is possible because ex_ready=0.
  3. Skid full, no consume: hold everything.
  4. Skid empty, accept, and (main empty or consume): input→main; main_valid←1.
  5. Skid empty, accept, main full, no consume: input→skid; skid_valid←1. This is the skid event.
  6. Skid empty, no accept, consume: main_valid←0.
  7. Otherwise: hold.
- Ordering: entries leave in acceptance order. The skid entry is never bypassed.
- Bubble masking: mem_we = main_valid & main_we; mem_memrw = main_valid ? main_memrw : MEMRW_IDLE. Other outputs show the raw main payload.
- Asserting rst mid-operation empties both slots asynchronously. In-flight entries are lost with no partial outputs.
- Legacy stall behaviour is obtained by tying mem_ready=~stall.

Decomposition:
- Shared package mcpu_pkg:
  - MEMRW_IDLE=2'b00, MEMRW_READ=2'b01, MEMRW_WRITE=2'b10.
  - WRITE_EN=1'b1, WRITE_DIS=1'b0.
  - Packed payload typedef ex_mem_payload_t {memrw, memaddr, memdata, wdata, waddr, we}, built from the parameters.
- One sub-module is natural: pipe_slot, a payload register plus valid bit with load/clear controls, instantiated twice (main, skid).
- Slot-steering control stays in ex_mem_skid.

Test Plan:
- Reset then pass-through: rst 1→0; ex_valid=1, wdata=1, waddr=1, we=1, mem_ready=1 → next cycle mem_valid=1, mem_wdata=1, mem_waddr=1, mem_we=1; ex_ready stays 1.
- Streaming: 4 back-to-back entries (wdata=1..4) with mem_ready=1 → mem_wdata 1,2,3,4 on consecutive cycles; skid_full never 1.
- Skid:
  - Setup: main holds A (wdata=5); drop mem_ready to 0 while ex_valid=1 with B (wdata=6).
  - Expected: B is accepted into skid; skid_full=1; ex_ready=0; mem_wdata stays 5.
  - Release: raise mem_ready → 5 then 6 out on consecutive cycles; ex_ready returns to 1.
- Flush:
  - Setup: main = MEMRW_WRITE, addr=2, data=2; skid full.
  - Stimulus: flush=1 for one cycle while ex_valid=1.
  - Expected: next cycle mem_valid=0, mem_memrw=IDLE, mem_we=0, skid_full=0; the flushing-cycle input is absent.
- Async reset mid-stream: rst asserted between clock edges with both slots full → mem_valid, mem_we and skid_full drop to 0 immediately, before the next edge.
- Backpressure stability: mem_ready=0 for 5 cycles with MEMRW_READ, addr=2 in main → all mem_* outputs constant across all 5 cycles.
